// File: rtl/sd_spi_card_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sd_spi_card_responder                                        |
// | Description : Card-side model of the SD SPI-mode command protocol.         |
// |               Receives 48-bit host command frames on spi_clk/cs/mosi,      |
// |               decodes CMD0/8/55/58 and ACMD41 and returns R1/R3/R7         |
// |               responses on miso after NCR_BYTES filler bytes.              |
// |               All SPI inputs are asynchronous and resynchronised to clk,   |
// |               which must run at least 4x faster than spi_clk.              |
// | Config      : define SD_RESP_CRC_CHECK_EN to check the CRC7 of each frame; |
// |               a bad CRC answers R1 with the CRC-error bit and the command  |
// |               is not executed. Undefined: the CRC field is ignored.        |
// | Ports       : clk, rst         system clock, synchronous active-high reset |
// |               spi_clk_i        host SPI clock (mode 0)                     |
// |               cs_i             chip select, active low                     |
// |               mosi_i / miso_o  host->card / card->host data, MSB first     |
// |               cmd_valid_o      1-clk pulse per decoded frame               |
// |               cmd_index_o      index of the last decoded command           |
// |               cmd_arg_o        argument of the last decoded command        |
// |               card_ready_o     ACMD41 initialisation complete              |
// |               busy_o           frame reception, NCR wait or response       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module sd_spi_card_responder #(
   parameter int          NCR_BYTES    = 1,
   parameter int          ACMD41_POLLS = 3,
   parameter logic [23:0] OCR_VOLT     = 24'hFF8000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        spi_clk_i,
   input  logic        cs_i,
   input  logic        mosi_i,
   output logic        miso_o,
   output logic        cmd_valid_o,
   output logic [5:0]  cmd_index_o,
   output logic [31:0] cmd_arg_o,
   output logic        card_ready_o,
   output logic        busy_o
);

   localparam int              POLL_W   = (ACMD41_POLLS > 0) ? $clog2(ACMD41_POLLS + 1) : 1;
   localparam logic [POLL_W-1:0] POLL_MAX = POLL_W'(ACMD41_POLLS);
   localparam logic [6:0]      NCR_LAST = 7'(NCR_BYTES * 8 - 1);

   // Only the bits that are needed at decode time are kept: index + argument,
   // plus the CRC field when it is checked. Older bits fall off the top.
`ifdef SD_RESP_CRC_CHECK_EN
   localparam int SH_W = 45;
`else
   localparam int SH_W = 38;
`endif
   localparam logic [5:0] SHIFT_LAST = 6'(SH_W + 1);

   typedef enum logic [1:0] {
      S_HUNT   = 2'd0,
      S_RX_CMD = 2'd1,
      S_NCR    = 2'd2,
      S_TX     = 2'd3
   } state_t;

   // ---------------------------------------------------------------- sync
   logic [1:0] sclk_sync_q;
   logic [1:0] cs_sync_q;
   logic [1:0] mosi_sync_q;
   logic       sclk_prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync_q <= 2'b00;
         cs_sync_q   <= 2'b11;
         mosi_sync_q <= 2'b11;
         sclk_prev_q <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[0], spi_clk_i};
         cs_sync_q   <= {cs_sync_q[0], cs_i};
         mosi_sync_q <= {mosi_sync_q[0], mosi_i};
         sclk_prev_q <= sclk_sync_q[1];
      end
   end

   logic w_sclk_rise;
   logic w_sclk_fall;
   logic w_cs_high;
   logic w_mosi;

   assign w_sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
   assign w_sclk_fall = ~sclk_sync_q[1] & sclk_prev_q;
   assign w_cs_high   = cs_sync_q[1];
   assign w_mosi      = mosi_sync_q[1];

   // ---------------------------------------------------------------- state
   state_t            state_q;
   logic [5:0]        bitcnt_q;
   logic [6:0]        cnt_q;
   logic [SH_W-1:0]   shift_q;
   logic [39:0]       resp_q;
   logic              resp_long_q;
   logic              miso_q;
   logic              cmd_valid_q;
   logic [5:0]        cmd_index_q;
   logic [31:0]       cmd_arg_q;
   logic              in_idle_q;
   logic              app_cmd_q;
   logic [POLL_W-1:0] poll_q;
   logic              ready_q;

   logic [5:0]  w_index;
   logic [31:0] w_arg;
   logic        w_crc_bad;

   assign w_index = shift_q[SH_W-1 -: 6];
   assign w_arg   = shift_q[SH_W-7 -: 32];

`ifdef SD_RESP_CRC_CHECK_EN
   function automatic logic [6:0] crc7(input logic [39:0] d);
      logic [6:0] c;
      logic       fb;
      c = 7'h00;
      for (int i = 39; i >= 0; i--) begin
         fb = d[i] ^ c[6];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   // Start and transmission bits are known (0,1) once the frame got this far.
   assign w_crc_bad = (crc7({2'b01, shift_q[44:7]}) != shift_q[6:0]);
`else
   assign w_crc_bad = 1'b0;
`endif

   // ---------------------------------------------------------------- decode
   logic [39:0]       resp_d;
   logic              resp_long_d;
   logic              in_idle_d;
   logic              app_cmd_d;
   logic [POLL_W-1:0] poll_d;
   logic              ready_d;

   always_comb begin
      in_idle_d   = in_idle_q;
      app_cmd_d   = 1'b0;                 // any command consumes a pending CMD55
      poll_d      = poll_q;
      ready_d     = ready_q;
      resp_d      = {5'b0, 1'b1, 1'b0, in_idle_q, 32'h0};   // illegal command
      resp_long_d = 1'b0;
      case (w_index)
         6'd0: begin
            in_idle_d = 1'b1;
            ready_d   = 1'b0;
            poll_d    = '0;
            resp_d    = {8'h01, 32'h0};
         end
         6'd8: begin
            if (w_arg[11:8] == 4'h1) begin
               resp_d      = {7'b0, in_idle_q, 16'h0, 4'h0, w_arg[11:8], w_arg[7:0]};
               resp_long_d = 1'b1;
            end
         end
         6'd55: begin
            app_cmd_d = 1'b1;
            resp_d    = {7'b0, in_idle_q, 32'h0};
         end
         6'd41: begin
            if (app_cmd_q) begin
               if (poll_q < POLL_MAX) begin
                  poll_d = poll_q + 1'b1;
                  resp_d = {8'h01, 32'h0};
               end else begin
                  in_idle_d = 1'b0;
                  ready_d   = 1'b1;
                  resp_d    = 40'h0;
               end
            end
         end
         6'd58: begin
            resp_d      = {7'b0, in_idle_q, ready_q, ready_q, 6'b0, OCR_VOLT};
            resp_long_d = 1'b1;
         end
         default: ;
      endcase
      if (w_crc_bad) begin
         in_idle_d   = in_idle_q;
         app_cmd_d   = app_cmd_q;
         poll_d      = poll_q;
         ready_d     = ready_q;
         resp_d      = {4'b0, 1'b1, 2'b0, in_idle_q, 32'h0};
         resp_long_d = 1'b0;
      end
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_HUNT;
         bitcnt_q    <= 6'd0;
         cnt_q       <= 7'd0;
         shift_q     <= '0;
         resp_q      <= 40'h0;
         resp_long_q <= 1'b0;
         miso_q      <= 1'b1;
         cmd_valid_q <= 1'b0;
         cmd_index_q <= 6'd0;
         cmd_arg_q   <= 32'h0;
         in_idle_q   <= 1'b1;
         app_cmd_q   <= 1'b0;
         poll_q      <= '0;
         ready_q     <= 1'b0;
      end else begin
         cmd_valid_q <= 1'b0;
         if (w_cs_high) begin
            // Deselect aborts whatever is in progress, including partial frames.
            state_q  <= S_HUNT;
            bitcnt_q <= 6'd0;
            cnt_q    <= 7'd0;
            miso_q   <= 1'b1;
         end else begin
            case (state_q)
               S_HUNT: begin
                  if (w_sclk_rise && !w_mosi) begin
                     state_q  <= S_RX_CMD;
                     bitcnt_q <= 6'd1;
                  end
               end
               S_RX_CMD: begin
                  if (w_sclk_rise) begin
                     if ((bitcnt_q == 6'd1) && !w_mosi) begin
                        // Transmission bit must be 1; otherwise resynchronise.
                        state_q  <= S_HUNT;
                        bitcnt_q <= 6'd0;
                     end else if (bitcnt_q == 6'd47) begin
                        // Stop bit: decode and commit the command.
                        cmd_index_q <= w_index;
                        cmd_arg_q   <= w_arg;
                        cmd_valid_q <= 1'b1;
                        resp_q      <= resp_d;
                        resp_long_q <= resp_long_d;
                        in_idle_q   <= in_idle_d;
                        app_cmd_q   <= app_cmd_d;
                        poll_q      <= poll_d;
                        ready_q     <= ready_d;
                        state_q     <= S_NCR;
                        cnt_q       <= 7'd0;
                        bitcnt_q    <= 6'd0;
                     end else begin
                        if (bitcnt_q <= SHIFT_LAST) begin
                           shift_q <= {shift_q[SH_W-2:0], w_mosi};
                        end
                        bitcnt_q <= bitcnt_q + 6'd1;
                     end
                  end
               end
               S_NCR: begin
                  if (w_sclk_fall) begin
                     miso_q <= 1'b1;
                     if (cnt_q == NCR_LAST) begin
                        state_q <= S_TX;
                        cnt_q   <= 7'd0;
                     end else begin
                        cnt_q <= cnt_q + 7'd1;
                     end
                  end
               end
               S_TX: begin
                  if (w_sclk_fall) begin
                     // The last bit stays on miso until the edge after it was sampled.
                     if (cnt_q == (resp_long_q ? 7'd40 : 7'd8)) begin
                        miso_q  <= 1'b1;
                        state_q <= S_HUNT;
                        cnt_q   <= 7'd0;
                     end else begin
                        miso_q <= resp_q[39];
                        resp_q <= {resp_q[38:0], 1'b0};
                        cnt_q  <= cnt_q + 7'd1;
                     end
                  end
               end
               default: state_q <= S_HUNT;
            endcase
         end
      end
   end

   assign miso_o       = miso_q;
   assign cmd_valid_o  = cmd_valid_q;
   assign cmd_index_o  = cmd_index_q;
   assign cmd_arg_o    = cmd_arg_q;
   assign card_ready_o = ready_q;
   assign busy_o       = (state_q != S_HUNT);

endmodule
`default_nettype wire

// File: tb/tb_sd_spi_card_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sd_spi_card_responder                                     |
// | Description : Scoreboard bench for sd_spi_card_responder. The host tasks   |
// |               push the expected command and response for every frame; a    |
// |               monitor pops an entry on each cmd_valid and collects the     |
// |               response bits from miso.                                     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_sd_spi_card_responder;

   localparam int NCR  = 1;
   localparam int HALF = 40;

   logic        clk     = 1'b0;
   logic        rst     = 1'b1;
   logic        spi_clk = 1'b0;
   logic        cs      = 1'b1;
   logic        mosi    = 1'b1;
   logic        miso;
   logic        cmd_valid;
   logic [5:0]  cmd_index;
   logic [31:0] cmd_arg;
   logic        card_ready;
   logic        busy;

   always #5 clk = ~clk;

   sd_spi_card_responder #(
      .NCR_BYTES    (NCR),
      .ACMD41_POLLS (3),
      .OCR_VOLT     (24'hFF8000)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .spi_clk_i    (spi_clk),
      .cs_i         (cs),
      .mosi_i       (mosi),
      .miso_o       (miso),
      .cmd_valid_o  (cmd_valid),
      .cmd_index_o  (cmd_index),
      .cmd_arg_o    (cmd_arg),
      .card_ready_o (card_ready),
      .busy_o       (busy)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [5:0]  idx;
      logic [31:0] arg;
      logic [39:0] resp;
      int          nbits;
      bit          chk_resp;
   } exp_t;

   exp_t sb[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [6:0] crc7(input logic [39:0] d);
      logic [6:0] c;
      logic       fb;
      c = 7'h00;
      for (int i = 39; i >= 0; i--) begin
         fb = d[i] ^ c[6];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   function automatic logic [47:0] mk(input logic [5:0] idx, input logic [31:0] arg);
      logic [39:0] d;
      d = {2'b01, idx, arg};
      return {d, crc7(d), 1'b1};
   endfunction

   function automatic logic [39:0] r1(input logic [7:0] b);
      return {b, 32'h0};
   endfunction

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         mosi = b[i];
         #HALF spi_clk = 1'b1;
         #HALF spi_clk = 1'b0;
      end
   endtask

   task automatic push_exp(input logic [47:0] f, input logic [39:0] resp, input int nbits,
                           input bit chk_resp);
      exp_t e;
      e.idx      = f[45:40];
      e.arg      = f[39:8];
      e.resp     = resp;
      e.nbits    = nbits;
      e.chk_resp = chk_resp;
      sb.push_back(e);
   endtask

   task automatic host_cmd(input logic [47:0] f, input logic [39:0] resp, input int nbits);
      push_exp(f, resp, nbits, 1'b1);
      @(negedge clk);
      cs = 1'b0;
      #(2*HALF);
      for (int i = 5; i >= 0; i--) send_byte(f[i*8 +: 8]);
      repeat (NCR + nbits/8 + 1) send_byte(8'hFF);
      #(2*HALF);
      cs = 1'b1;
      #(4*HALF);
   endtask

   // ---------------------------------------------------------------- monitor
   initial begin : monitor
      exp_t        e;
      int          ones;
      bit          seen;
      logic [39:0] cap;
      forever begin
         @(negedge clk);
         if (cmd_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected_cmd_valid", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               chk("cmd_index", cmd_index, e.idx);
               chk("cmd_arg", cmd_arg, e.arg);
               if (e.chk_resp) begin
                  ones = 0;
                  seen = 1'b0;
                  for (int k = 0; k < 128 && !seen; k++) begin
                     @(posedge spi_clk);
                     if (miso === 1'b0) seen = 1'b1;
                     else ones++;
                  end
                  if (!seen) begin
                     chk("resp_start_timeout", 64'd0, 64'd1);
                  end else begin
                     cap = 40'h0;
                     for (int k = 1; k < e.nbits; k++) begin
                        @(posedge spi_clk);
                        cap[39-k] = miso;
                     end
                     chk("ncr_len", ones, NCR*8);
                     chk("response", cap, e.resp);
                  end
               end
            end
         end
      end
   end

   initial begin : watchdog
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- stimulus
   initial begin : stim
      repeat (4) @(negedge clk);
      chk("rst_miso", miso, 1'b1);
      chk("rst_cmd_valid", cmd_valid, 1'b0);
      chk("rst_cmd_index", cmd_index, 6'd0);
      chk("rst_cmd_arg", cmd_arg, 32'h0);
      chk("rst_card_ready", card_ready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      host_cmd(48'h40_0000_0000_95, r1(8'h01), 8);
      host_cmd(48'h48_0000_01AA_87, 40'h01_0000_01AA, 40);
      host_cmd(mk(6'd8, 32'h0000_02AA), r1(8'h05), 8);
      host_cmd(mk(6'd58, 32'h0), 40'h01_00FF_8000, 40);

      for (int i = 0; i < 4; i++) begin
         chk("ready_during_init", card_ready, 1'b0);
         host_cmd(mk(6'd55, 32'h0), r1(8'h01), 8);
         host_cmd(mk(6'd41, 32'h4000_0000), r1((i < 3) ? 8'h01 : 8'h00), 8);
      end
      chk("ready_after_init", card_ready, 1'b1);

      host_cmd(mk(6'd58, 32'h0), 40'h00_C0FF_8000, 40);
      host_cmd(mk(6'd41, 32'h4000_0000), r1(8'h04), 8);   // no preceding CMD55
      host_cmd(mk(6'd17, 32'h0000_1000), r1(8'h04), 8);
      host_cmd(mk(6'd55, 32'h0), r1(8'h00), 8);
      host_cmd(mk(6'd58, 32'h0), 40'h00_C0FF_8000, 40);  // consumes app_cmd
      host_cmd(mk(6'd41, 32'h4000_0000), r1(8'h04), 8);
      host_cmd(mk(6'd55, 32'h0), r1(8'h00), 8);
      host_cmd(mk(6'd41, 32'h4000_0000), r1(8'h00), 8);   // saturated poll count

      // Frame with transmission bit 0 must be dropped silently.
      @(negedge clk);
      cs = 1'b0;
      #(2*HALF);
      send_byte(8'h3F);
      repeat (7) send_byte(8'hFF);
      #(2*HALF);
      chk("bad_tx_bit_busy", busy, 1'b0);
      cs = 1'b1;
      #(4*HALF);

      // CMD0 with a zero CRC byte while the card is ready.
`ifdef SD_RESP_CRC_CHECK_EN
      host_cmd(48'h40_0000_0000_00, r1(8'h08), 8);
      chk("crc_bad_ready_kept", card_ready, 1'b1);
`else
      host_cmd(48'h40_0000_0000_00, r1(8'h01), 8);
      chk("crc_ignored_ready_cleared", card_ready, 1'b0);
`endif

      // Partial frame aborted by cs, then a full CMD0.
      @(negedge clk);
      cs = 1'b0;
      #(2*HALF);
      send_byte(8'h40);
      send_byte(8'h00);
      send_byte(8'h00);
      #(2*HALF);
      cs = 1'b1;
      #(4*HALF);
      chk("abort_busy", busy, 1'b0);
      host_cmd(48'h40_0000_0000_95, r1(8'h01), 8);
      chk("cmd0_ready_cleared", card_ready, 1'b0);

      // Reset while the response is on the wire.
      push_exp(mk(6'd58, 32'h0), 40'h0, 40, 1'b0);
      @(negedge clk);
      cs = 1'b0;
      #(2*HALF);
      for (int i = 5; i >= 0; i--) send_byte(mk(6'd58, 32'h0) >> (i*8));
      repeat (NCR) send_byte(8'hFF);
      #60;
      chk("tx_first_bit", miso, 1'b0);
      chk("tx_busy", busy, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_tx_miso", miso, 1'b1);
      chk("rst_mid_tx_busy", busy, 1'b0);
      rst = 1'b0;
      cs  = 1'b1;
      #(4*HALF);

`ifdef SD_RESP_CRC_CHECK_EN
      host_cmd(48'h40_0000_0000_00, r1(8'h09), 8);
`else
      host_cmd(48'h40_0000_0000_00, r1(8'h01), 8);
`endif
      host_cmd(mk(6'd58, 32'h0), 40'h01_00FF_8000, 40);

      #(8*HALF);
      chk("scoreboard_drained", sb.size(), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
